uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of uart_rx. Detects each completed reception from uart_rx's level-held status outputs and pushes one tagged entry (data byte, parity error, frame error) into a circular FIFO. Exposes a first-word-fall-through read port, occupancy count, watermark flag and sticky overrun flag to the UART register/interrupt logic.

Parameters:
DEPTH, 8, number of entries; power of two, minimum 2
STORE_ERRORS, 1, 1: errored frames are stored with their flags; 0: errored frames are dropped and only counted

Ports:
clock  in  1  system clock, same domain as uart_rx
reset  in  1  asynchronous, active-low reset (asserted at 0)
rx_data  in  8  uart_rx data_out
rx_data_valid  in  1  uart_rx data_valid (level, held until next reception)
rx_parity_error  in  1  uart_rx parity_error (level)
rx_frame_error  in  1  uart_rx frame_error (level)
flush  in  1  synchronous clear of contents and overrun flag
rd_en  in  1  pop head entry
threshold  in  $clog2(DEPTH+1)  watermark level
rd_data  out  8  head entry data byte
rd_parity_error  out  1  head entry parity flag
rd_frame_error  out  1  head entry frame flag
empty  out  1  no entries
full  out  1  DEPTH entries
count  out  $clog2(DEPTH+1)  occupancy
watermark  out  1  count > threshold
overrun  out  1  sticky: a frame was lost because FIFO was full
drop_count  out  8  saturating count of frames dropped (overrun or STORE_ERRORS=0 errors)

Behaviour:
- Reset (reset=0, async): pointers=0, count=0, empty=1, full=0, watermark=0, overrun=0, drop_count=0, rd_data/flags=0, edge register=0.
- Frame detect: done = rx_data_valid | rx_parity_error | rx_frame_error; register done_q; push request on done & ~done_q (rising edge), exactly one per reception. uart_rx drops all three in Start state, so back-to-back frames give distinct edges.
- Entry captured at the edge cycle: {rx_parity_error, rx_frame_error, rx_data}. Entry visible (empty=0) the cycle after the edge.
- STORE_ERRORS=0 and (parity or frame error): no push; drop_count increments.
- Push while full and no pop that cycle: entry discarded, overrun<=1, drop_count increments; contents unchanged.
- Push and pop same cycle: when full, pop frees slot and push succeeds (no overrun), count unchanged; when empty, pop ignored, push succeeds, count becomes 1; otherwise count unchanged.
- rd_en while empty: ignored, no pointer change, no error.
- FWFT: rd_data/rd_*_error show head entry whenever empty=0; rd_en pops, next entry visible the following cycle. Outputs hold last value when empty (not valid).
- Pointers $clog2(DEPTH)+1 bits; wrap modulo DEPTH; full = MSBs differ and lower bits equal.
- watermark combinational from count and threshold; threshold >= DEPTH keeps it 0.
- flush: next cycle pointers=0, count=0, overrun=0, drop_count=0; a push edge in the flush cycle is discarded (not counted). flush has priority over push/pop.
- drop_count saturates at 255.
- Reset mid-reception: edge register cleared; if done is already high after reset release, that level generates a push on the first clocked cycle (accepted behaviour).

Decomposition:
- uart_phy_pkg: add rx_entry_t packed struct {parity_error, frame_error, data[7:0]} and constant UART_DATA_WIDTH=8.
- One sub-module: sync_fifo (generic DEPTH x WIDTH storage, pointers, full/empty, count), reusable for the TX side; uart_rx_fifo adds edge detect, error filtering, overrun, drop counter, watermark.

Test Plan:
- Reset then idle: all outputs at reset values; empty=1, count=0, watermark=0 for 20 cycles with done low.
- Three clean frames 0xA5, 0x3C, 0xFF (valid level held 10 cycles each, dropped between): count=3, rd_data=0xA5, pops return 0x3C, 0xFF, then empty=1; only one entry per held level.
- Frame 0x12 with parity_error, STORE_ERRORS=1: entry stored, rd_parity_error=1, rd_frame_error=0; STORE_ERRORS=0: count stays 0, drop_count=1.
- Fill DEPTH=8 frames, send 9th (0x99): full=1, overrun=1, drop_count=1, head still frame 1; repeat with rd_en in the 9th edge cycle: overrun stays 0, count=8, 0x99 at tail.
- threshold=2: watermark=0 at count 2, 1 at count 3, 0 after one pop; flush: count=0, overrun=0, drop_count=0 next cycle.
- Assert reset=0 asynchronously between clock edges with count=5: outputs return to reset values immediately, before next clock edge.

Source files
------------

// File: rtl/uart_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_phy_pkg
// Description : Shared types and constants for the UART datapath.
//               rx_entry_t is the tagged word stored by the receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_phy_pkg;

   localparam int UART_DATA_WIDTH = 8;

   typedef struct packed {
      logic                       parity_error;
      logic                       frame_error;
      logic [UART_DATA_WIDTH-1:0] data;
   } rx_entry_t;

   localparam int RX_ENTRY_WIDTH = $bits(rx_entry_t);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Generic single-clock circular FIFO, first-word-fall-through.
//               A push is accepted while not full, or while full if a pop
//               happens in the same cycle. A pop while empty is ignored.
//               flush clears the pointers and overrides push and pop.
// Ports       : clock, reset (async, active-low), flush, push, pop,
//               wr_data  - word written on an accepted push
//               rd_data  - head word while non-empty, last popped word otherwise
//               empty, full, count (occupancy 0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [PTR_W-1:0] count
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic             do_push, do_pop;

   assign wr_addr = wr_ptr_q[ADDR_W-1:0];
   assign rd_addr = rd_ptr_q[ADDR_W-1:0];

   // The extra pointer MSB distinguishes full from empty when addresses match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_addr == rd_addr);
   assign count = wr_ptr_q - rd_ptr_q;

   // Popping a full FIFO frees the slot the simultaneous push lands in.
   assign do_pop  = pop  & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   // When empty the read port keeps showing the most recently popped word.
   assign rd_data = empty ? last_q : mem_q[rd_addr];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_addr];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         last_q   <= last_d;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_addr] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive buffer behind uart_rx. Turns the rising edge of the
//               receiver's level-held status into one tagged FIFO push,
//               optionally discards errored frames, and tracks overrun,
//               dropped-frame count and a watermark for the register block.
// Ports       : clock, reset (async, active-low)
//               rx_data/rx_data_valid/rx_parity_error/rx_frame_error - uart_rx
//               flush - synchronous clear; rd_en - pop head entry
//               threshold - watermark level (watermark = count > threshold)
//               rd_data/rd_parity_error/rd_frame_error - FWFT head entry
//               empty, full, count, watermark, overrun (sticky), drop_count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
   import uart_phy_pkg::*;
#(
   parameter  int DEPTH        = 8,
   parameter  int STORE_ERRORS = 1,
   localparam int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_data_valid,
   input  logic             rx_parity_error,
   input  logic             rx_frame_error,
   input  logic             flush,
   input  logic             rd_en,
   input  logic [CNT_W-1:0] threshold,
   output logic [7:0]       rd_data,
   output logic             rd_parity_error,
   output logic             rd_frame_error,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             watermark,
   output logic             overrun,
   output logic [7:0]       drop_count
);

   logic       done_q, done_d;
   logic       overrun_q, overrun_d;
   logic [7:0] drop_count_q, drop_count_d;

   logic       done, push_edge, frame_err, filtered;
   logic       push_req, lost, drop_evt;
   rx_entry_t  wr_entry, rd_entry;

   always_comb begin
      // uart_rx clears all three status levels in its Start state, so each
      // reception produces exactly one rising edge of done.
      done      = rx_data_valid | rx_parity_error | rx_frame_error;
      push_edge = done & ~done_q;
      frame_err = rx_parity_error | rx_frame_error;
      filtered  = (STORE_ERRORS == 0) && frame_err;

      push_req  = push_edge & ~flush & ~filtered;
      // A pop in the same cycle makes room, so only an unpopped full FIFO loses data.
      lost      = push_req & full & ~rd_en;
      drop_evt  = (push_edge & ~flush & filtered) | lost;

      done_d    = done;
      overrun_d = flush ? 1'b0 : (overrun_q | lost);
      if (flush)         drop_count_d = '0;
      else if (drop_evt) drop_count_d = sat_inc8(drop_count_q);
      else               drop_count_d = drop_count_q;

      wr_entry.parity_error = rx_parity_error;
      wr_entry.frame_error  = rx_frame_error;
      wr_entry.data         = rx_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
         drop_count_q <= '0;
      end else begin
         done_q       <= done_d;
         overrun_q    <= overrun_d;
         drop_count_q <= drop_count_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RX_ENTRY_WIDTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .push    (push_req),
      .pop     (rd_en),
      .wr_data (wr_entry),
      .rd_data (rd_entry),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   assign rd_data         = rd_entry.data;
   assign rd_parity_error = rd_entry.parity_error;
   assign rd_frame_error  = rd_entry.frame_error;
   // count never exceeds DEPTH, so threshold >= DEPTH holds this low.
   assign watermark       = (count > threshold);
   assign overrun         = overrun_q;
   assign drop_count      = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench. Two instances (STORE_ERRORS=1 and 0)
//               share stimulus; each is compared every cycle against a
//               queue-based reference model of the receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0, rx_pe = 1'b0, rx_fe = 1'b0;
   logic          flush = 1'b0, rd_en = 1'b0;
   logic [CW-1:0] threshold = CW'(DEPTH);

   logic [7:0]    o_data [2];
   logic          o_pe [2], o_fe [2], o_empty [2], o_full [2], o_wm [2], o_ov [2];
   logic [CW-1:0] o_count [2];
   logic [7:0]    o_dc [2];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .STORE_ERRORS(1)) dut0 (
      .clock(clk), .reset(reset_n), .rx_data(rx_data), .rx_data_valid(rx_valid),
      .rx_parity_error(rx_pe), .rx_frame_error(rx_fe), .flush(flush), .rd_en(rd_en),
      .threshold(threshold), .rd_data(o_data[0]), .rd_parity_error(o_pe[0]),
      .rd_frame_error(o_fe[0]), .empty(o_empty[0]), .full(o_full[0]), .count(o_count[0]),
      .watermark(o_wm[0]), .overrun(o_ov[0]), .drop_count(o_dc[0]));

   uart_rx_fifo #(.DEPTH(DEPTH), .STORE_ERRORS(0)) dut1 (
      .clock(clk), .reset(reset_n), .rx_data(rx_data), .rx_data_valid(rx_valid),
      .rx_parity_error(rx_pe), .rx_frame_error(rx_fe), .flush(flush), .rd_en(rd_en),
      .threshold(threshold), .rd_data(o_data[1]), .rd_parity_error(o_pe[1]),
      .rd_frame_error(o_fe[1]), .empty(o_empty[1]), .full(o_full[1]), .count(o_count[1]),
      .watermark(o_wm[1]), .overrun(o_ov[1]), .drop_count(o_dc[1]));

   // ---------------- reference model ----------------
   logic [9:0] q0[$], q1[$];
   logic [9:0] last_m [2];
   bit         ov_m [2];
   int         dc_m [2];
   bit         done_m;

   int checks = 0;
   int errors = 0;
   bit rand_rd = 0;
   int rd_pct = 40;

   function automatic int msize(int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [9:0] mhead(int k);
      if (msize(k) == 0) return last_m[k];
      return (k == 0) ? q0[0] : q1[0];
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         last_m[k] = '0;
         ov_m[k]   = 0;
         dc_m[k]   = 0;
      end
      done_m = 0;
   endtask

   task automatic model_clock();
      bit d, e, pop, push;
      int sz;
      d = rx_valid | rx_pe | rx_fe;
      e = d && !done_m;
      done_m = d;
      for (int k = 0; k < 2; k++) begin
         if (flush) begin
            if (k == 0) q0.delete(); else q1.delete();
            ov_m[k] = 0;
            dc_m[k] = 0;
         end else begin
            sz   = msize(k);
            pop  = rd_en && (sz > 0);
            push = 0;
            if (e) begin
               if (k == 1 && (rx_pe || rx_fe)) begin
                  if (dc_m[k] < 255) dc_m[k]++;
               end else if (sz == DEPTH && !pop) begin
                  ov_m[k] = 1;
                  if (dc_m[k] < 255) dc_m[k]++;
               end else begin
                  push = 1;
               end
            end
            if (pop) begin
               last_m[k] = mhead(k);
               if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (push) begin
               if (k == 0) q0.push_back({rx_pe, rx_fe, rx_data});
               else        q1.push_back({rx_pe, rx_fe, rx_data});
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int sz;
      for (int k = 0; k < 2; k++) begin
         sz = msize(k);
         chk($sformatf("empty%0d", k), 32'(o_empty[k]), 32'(sz == 0));
         chk($sformatf("full%0d", k),  32'(o_full[k]),  32'(sz == DEPTH));
         chk($sformatf("count%0d", k), 32'(o_count[k]), 32'(sz));
         chk($sformatf("wmark%0d", k), 32'(o_wm[k]),    32'(sz > int'(threshold)));
         chk($sformatf("ovrun%0d", k), 32'(o_ov[k]),    32'(ov_m[k]));
         chk($sformatf("drops%0d", k), 32'(o_dc[k]),    32'(dc_m[k]));
         chk($sformatf("head%0d", k),  32'({o_pe[k], o_fe[k], o_data[k]}), 32'(mhead(k)));
      end
   endtask

   task automatic tick();
      if (rand_rd) rd_en = ($urandom_range(0, 99) < rd_pct);
      @(posedge clk);
      if (!reset_n) model_reset();
      else          model_clock();
      #1;
      check_all();
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pe, input bit fe,
                             input int hold, input int gap, input bit pop_edge);
      rx_data  = d;
      rx_pe    = pe;
      rx_fe    = fe;
      rx_valid = !(pe || fe);
      if (pop_edge) rd_en = 1;
      tick();
      if (pop_edge) rd_en = 0;
      repeat (hold - 1) tick();
      rx_valid = 0;
      rx_pe    = 0;
      rx_fe    = 0;
      repeat (gap) tick();
   endtask

   task automatic pop1();
      rd_en = 1;
      tick();
      rd_en = 0;
   endtask

   task automatic do_flush();
      flush = 1;
      tick();
      flush = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      repeat (2) tick();
      reset_n = 1;
      repeat (20) tick();

      // three clean frames, long held levels
      send_frame(8'hA5, 0, 0, 10, 2, 0);
      send_frame(8'h3C, 0, 0, 10, 2, 0);
      send_frame(8'hFF, 0, 0, 10, 2, 0);
      chk("tp_cnt3", 32'(o_count[0]), 32'd3);
      chk("tp_headA5", 32'(o_data[0]), 32'h0A5);
      pop1();
      chk("tp_head3C", 32'(o_data[0]), 32'h03C);
      pop1();
      chk("tp_headFF", 32'(o_data[0]), 32'h0FF);
      pop1();
      chk("tp_empty", 32'(o_empty[0]), 32'd1);

      // parity-errored frame: stored by one instance, dropped by the other
      send_frame(8'h12, 1, 0, 4, 2, 0);
      chk("tp_pe_stored", 32'({o_pe[0], o_fe[0], o_data[0]}), 32'h212);
      chk("tp_pe_cnt1", 32'(o_count[1]), 32'd0);
      chk("tp_pe_drop1", 32'(o_dc[1]), 32'd1);
      do_flush();

      // fill then overrun
      for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), 0, 0, 2, 1, 0);
      send_frame(8'h99, 0, 0, 2, 1, 0);
      chk("tp_full", 32'(o_full[0]), 32'd1);
      chk("tp_ovr", 32'(o_ov[0]), 32'd1);
      chk("tp_ovr_dc", 32'(o_dc[0]), 32'd1);
      chk("tp_ovr_head", 32'(o_data[0]), 32'h01);
      do_flush();
      chk("tp_flush_ovr", 32'(o_ov[0]), 32'd0);

      // fill then push with simultaneous pop: no overrun
      for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), 0, 0, 2, 1, 0);
      send_frame(8'h99, 0, 0, 2, 1, 1);
      chk("tp_pp_ovr", 32'(o_ov[0]), 32'd0);
      chk("tp_pp_cnt", 32'(o_count[0]), 32'd8);
      repeat (DEPTH - 1) pop1();
      chk("tp_pp_tail", 32'(o_data[0]), 32'h099);
      do_flush();

      // watermark at threshold 2
      threshold = CW'(2);
      send_frame(8'h21, 0, 0, 2, 1, 0);
      send_frame(8'h22, 0, 0, 2, 1, 0);
      chk("tp_wm2", 32'(o_wm[0]), 32'd0);
      send_frame(8'h23, 0, 0, 2, 1, 0);
      chk("tp_wm3", 32'(o_wm[0]), 32'd1);
      pop1();
      chk("tp_wm_pop", 32'(o_wm[0]), 32'd0);
      do_flush();
      chk("tp_flush_cnt", 32'(o_count[0]), 32'd0);

      // asynchronous reset between clock edges with five entries held
      for (int i = 0; i < 5; i++) send_frame(8'h50 + 8'(i), 0, 0, 2, 1, 0);
      chk("tp_cnt5", 32'(o_count[0]), 32'd5);
      #2;
      reset_n = 0;
      model_reset();
      #1;
      check_all();
      chk("tp_arst_empty", 32'(o_empty[0]), 32'd1);
      tick();
      reset_n = 1;
      threshold = CW'(DEPTH);
      repeat (3) tick();

      // randomized traffic
      rand_rd = 1;
      for (int i = 0; i < 300; i++) begin
         rd_pct = (i < 150) ? 15 : 55;
         if ($urandom_range(0, 39) == 0) do_flush();
         if ($urandom_range(0, 19) == 0) threshold = CW'($urandom_range(0, DEPTH));
         send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(1, 4), $urandom_range(1, 3), 0);
      end
      rand_rd = 0;
      rd_en = 0;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
